// File: rtl/l2ram_sdp_lanes.sv
// l2ram_sdp_lanes: simple-dual-port lane-enabled buffer RAM with zero-fill sweep and ready flag
// Ports: clock, rst_n (async active-low); clear restarts the zero-fill sweep; ready = sweep done;
//   write port wren/wraddress/be/data (be[i] covers data lane i); read port rden/rdaddress -> q/q_valid.
// Define L2RAM_OUTREG_EN for an extra output register (read latency 2); default latency 1.
module l2ram_sdp_lanes #(
  parameter int DATA_W = 48,
  parameter int DEPTH = 16,
  parameter int LANE_W = 8,
  parameter int FORWARD = 1,
  localparam int NLANE = DATA_W / LANE_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [NLANE-1:0]  be,
  input  logic [DATA_W-1:0] data,
  input  logic              rden,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [0:0] state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, wr_go, rd_go, rd_ok, a_v;
  logic [DATA_W-1:0] rd_word, a_q;
  assign ready = state == S_READY;
  // clear takes priority over any access in the same cycle
  assign acc = ready & ~clear;
  assign rd_ok = {1'b0, rdaddress} < DEPTH_X;
  assign wr_go = acc & wren & ({1'b0, wraddress} < DEPTH_X);
  assign rd_go = acc & rden;
  // array read, with new lanes merged in on a same-address write when forwarding
  always_comb begin
    rd_word = rd_ok ? mem[rdaddress] : '0;
    for (int i = 0; i < NLANE; i++)
      if (FORWARD != 0 && wr_go && wraddress == rdaddress && be[i])
        rd_word[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state <= S_INIT;
      cnt <= '0;
    end else if (clear) begin
      state <= S_INIT;
      cnt <= '0;
    end else if (state == S_INIT) begin
      state <= cnt == LAST ? S_READY : S_INIT;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
    end
  always_ff @(posedge clock)
    if (state == S_INIT)
      mem[cnt] <= '0;
    else if (wr_go)
      for (int i = 0; i < NLANE; i++)
        if (be[i]) mem[wraddress][i*LANE_W +: LANE_W] <= data[i*LANE_W +: LANE_W];
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      a_v <= 1'b0;
    end else begin
      a_v <= rd_go;
      if (rd_go) a_q <= rd_word;
    end
`ifdef L2RAM_OUTREG_EN
  // second stage; clear drops whatever read is in flight
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= a_v & ~clear;
      if (a_v & ~clear) q <= a_q;
    end
`else
  assign q = a_q;
  assign q_valid = a_v;
`endif
endmodule

// File: tb/tb_l2ram_sdp_lanes.sv
// tb_l2ram_sdp_lanes: directed bench with a behavioural RAM model checked every cycle
module tb_l2ram_sdp_lanes;
  localparam int DATA_W = 48;
  localparam int DEPTH = 16;
  localparam int FORWARD = 1;
`ifdef L2RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clock = 1'b0;
  logic rst_n, clear, wren, rden, ready, q_valid;
  logic [3:0] wraddress, rdaddress;
  logic [5:0] be;
  logic [47:0] data, q;
  int n_tests = 0;
  int n_fail = 0;
  l2ram_sdp_lanes #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANE_W(8), .FORWARD(FORWARD)) dut (
    .clock(clock), .rst_n(rst_n), .clear(clear), .ready(ready),
    .wren(wren), .wraddress(wraddress), .be(be), .data(data),
    .rden(rden), .rdaddress(rdaddress), .q(q), .q_valid(q_valid)
  );
  always #5 clock = ~clock;
  function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // model: ready counts down DEPTH cycles, then the whole array is zero
  logic [47:0] mm [DEPTH];
  logic m_ready = 1'b0, e_v = 1'b0, s_v = 1'b0, acc_m, rv;
  logic [47:0] e_q = '0, s_q = '0, res;
  int left = DEPTH;
  always @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      m_ready = 1'b0; left = DEPTH; e_v = 1'b0; e_q = '0; s_v = 1'b0; s_q = '0;
    end else begin
      acc_m = m_ready && !clear;
      rv = acc_m && rden;
      res = int'(rdaddress) < DEPTH ? mm[rdaddress] : '0;
      if (rv && FORWARD != 0 && wren && wraddress == rdaddress)
        for (int i = 0; i < 6; i++) if (be[i]) res[i*8 +: 8] = data[i*8 +: 8];
      if (acc_m && wren && int'(wraddress) < DEPTH)
        for (int i = 0; i < 6; i++) if (be[i]) mm[wraddress][i*8 +: 8] = data[i*8 +: 8];
      if (LAT == 1) begin
        e_v = rv;
        if (rv) e_q = res;
      end else begin
        e_v = !clear && s_v;
        if (!clear && s_v) e_q = s_q;
        s_v = rv;
        if (rv) s_q = res;
      end
      if (clear) begin
        m_ready = 1'b0; left = DEPTH;
      end else if (!m_ready) begin
        left = left - 1;
        if (left == 0) begin
          m_ready = 1'b1;
          foreach (mm[k]) mm[k] = '0;
        end
      end
    end
  always @(negedge clock) begin
    chk("model ready", 48'(ready), 48'(m_ready));
    chk("model q_valid", 48'(q_valid), 48'(e_v));
    chk("model q", q, e_q);
  end
  task automatic step();
    @(negedge clock);
  endtask
  task automatic idle();
    wren = 1'b0; rden = 1'b0; clear = 1'b0;
  endtask
  task automatic wr1(input logic [3:0] a, input logic [47:0] d, input logic [5:0] b);
    wren = 1'b1; wraddress = a; data = d; be = b;
    step();
    wren = 1'b0;
  endtask
  task automatic rd1(input logic [3:0] a, input logic [47:0] exp, input string name);
    rden = 1'b1; rdaddress = a;
    step();
    rden = 1'b0;
    repeat (LAT - 1) step();
    chk({name, " q"}, q, exp);
    chk({name, " q_valid"}, 48'(q_valid), 48'd1);
  endtask
  task automatic sweep_check(input string name);
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      chk(name, 48'(ready), k == DEPTH ? 48'd1 : 48'd0);
    end
  endtask
  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rden = 1'b1; rdaddress = 4'(a);
      step();
    end
    rden = 1'b0;
    repeat (LAT) step();
  endtask
  initial begin
    rst_n = 1'b0; idle(); wraddress = '0; rdaddress = '0; be = '0; data = '0;
    repeat (3) step();
    chk("reset q", q, 48'd0);
    chk("reset q_valid", 48'(q_valid), 48'd0);
    chk("reset ready", 48'(ready), 48'd0);
    rst_n = 1'b1;
    chk("ready at release", 48'(ready), 48'd0);
    sweep_check("initial sweep ready");
    read_all();
    rd1(4'd15, 48'd0, "post-sweep addr15");
    wr1(4'd3, 48'hA1B2C3D4E5F6, 6'h3F);
    rd1(4'd3, 48'hA1B2C3D4E5F6, "full write");
    wr1(4'd3, 48'h111111111111, 6'h05);
    rd1(4'd3, 48'hA1B2C311E511, "lane write");
    wr1(4'd3, 48'h0, 6'h00);
    rd1(4'd3, 48'hA1B2C311E511, "be zero");
    wren = 1'b1; rden = 1'b1; wraddress = 4'd5; rdaddress = 4'd5;
    data = 48'hFFFF00000000; be = 6'h3F;
    step();
    idle();
    repeat (LAT - 1) step();
    chk("rdw same addr", q, FORWARD != 0 ? 48'hFFFF00000000 : 48'd0);
    rd1(4'd5, 48'hFFFF00000000, "after rdw");
    wren = 1'b1; rden = 1'b1; wraddress = 4'd7; rdaddress = 4'd3;
    data = 48'h0123456789AB; be = 6'h3F;
    step();
    idle();
    repeat (LAT - 1) step();
    chk("rdw diff addr", q, 48'hA1B2C311E511);
    rd1(4'd7, 48'h0123456789AB, "diff addr write");
    for (int i = 0; i < 5; i++) begin
      rden = 1'b1; rdaddress = 4'(i);
      if (i == 4) begin
        clear = 1'b1; wren = 1'b1; wraddress = 4'd9; data = '1; be = 6'h3F;
      end
      step();
    end
    clear = 1'b0;
    chk("clear q_valid", 48'(q_valid), 48'd0);
    chk("clear ready", 48'(ready), 48'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      rdaddress = 4'(k); wraddress = 4'(k);
      step();
      chk("clear sweep ready", 48'(ready), k == DEPTH ? 48'd1 : 48'd0);
    end
    idle();
    read_all();
    rd1(4'd9, 48'd0, "ignored write");
    rd1(4'd7, 48'd0, "cleared addr7");
    wr1(4'd3, 48'hDEADBEEF0001, 6'h3F);
    rd1(4'd3, 48'hDEADBEEF0001, "pre-reset read");
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset q", q, 48'd0);
    chk("async reset q_valid", 48'(q_valid), 48'd0);
    chk("async reset ready", 48'(ready), 48'd0);
    step();
    rst_n = 1'b1;
    sweep_check("resweep ready");
    rd1(4'd3, 48'd0, "resweep addr3");
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
